// File: rtl/alu_pkg.sv
// Shared ALU opcode constants, sequencer state encoding and opcode helpers.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'h4;
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'h5;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'h6;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'h7;
  localparam logic [ALU_OP_W-1:0] ALU_LUI  = 4'h8;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'h9;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'hA;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Shifts are the only opcodes that iterate one bit per cycle.
  function automatic logic is_shift(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Control stage in front of the ALU operation decoder: accepts one operation
// per handshake and holds the decoder enabled for as many cycles as the
// operation needs (one for plain ops, shamt cycles for shifts).
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [OP_W-1:0]    op_code,
  input  logic [SHAMT_W-1:0] op_shamt,
  output logic               op_ready,
  input  logic               flush,
  output logic               dec_en,
  output logic [OP_W-1:0]    dec_sel,
  output logic               busy,
  output logic               done,
  output logic [SHAMT_W-1:0] iter_left
);

  seq_state_t         state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]    sel_q, sel_d;
  logic               accept;
  logic               op_is_shift;

  // Ready is blocked during EXEC, and also while reset or flush are asserted
  // so a same-cycle handshake is never taken.
  assign op_ready    = (state_q != EXEC) && !rst && !flush;
  assign accept      = op_valid && op_ready;
  assign op_is_shift = is_shift(ALU_OP_W'(op_code));

  // Next-state, counter and select decode; a zero-amount shift completes
  // straight away without touching the decoder select.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (op_is_shift && (op_shamt == '0)) begin
              state_d = DONE;
              cnt_d   = '0;
            end else begin
              state_d = EXEC;
              sel_d   = op_code;
              cnt_d   = op_is_shift ? op_shamt : SHAMT_W'(1);
            end
          end else if (state_q == DONE) begin
            state_d = IDLE;
          end
        end
        EXEC: begin
          cnt_d = cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, iteration counter and latched select registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  assign dec_en    = (state_q == EXEC);
  assign busy      = (state_q == EXEC);
  assign done      = (state_q == DONE);
  assign dec_sel   = sel_q;
  assign iter_left = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a table of operations plus
// hand-written back-to-back, flush and reset sequences; per-cycle expected
// outputs are queued at acceptance and compared one per clock.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst;
  logic       op_valid;
  logic [3:0] op_code;
  logic [4:0] op_shamt;
  logic       op_ready;
  logic       flush;
  logic       dec_en;
  logic [3:0] dec_sel;
  logic       busy;
  logic       done;
  logic [4:0] iter_left;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       en;
    logic [3:0] sel;
    logic       bsy;
    logic       dn;
    logic       rdy;
    logic [4:0] iter;
  } exp_t;

  typedef struct packed {
    logic [3:0] code;
    logic [4:0] shamt;
    logic [5:0] cycles;
  } vec_t;

  exp_t       expq[$];
  logic [3:0] predSel;

  alu_op_sequencer #(.OP_W(4), .SHAMT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_shamt (op_shamt),
    .op_ready (op_ready),
    .flush    (flush),
    .dec_en   (dec_en),
    .dec_sel  (dec_sel),
    .busy     (busy),
    .done     (done),
    .iter_left(iter_left)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare every DUT output against one expected cycle record.
  task automatic checkOutput(input exp_t e);
    checks++;
    if (dec_en !== e.en || dec_sel !== e.sel || busy !== e.bsy ||
        done !== e.dn || op_ready !== e.rdy || iter_left !== e.iter) begin
      errors++;
      $display("[TB] FAIL outputs t=%0t got en=%b sel=%h busy=%b done=%b rdy=%b iter=%0d want en=%b sel=%h busy=%b done=%b rdy=%b iter=%0d",
               $time, dec_en, dec_sel, busy, done, op_ready, iter_left,
               e.en, e.sel, e.bsy, e.dn, e.rdy, e.iter);
    end
  endtask

  // Scoreboard consumer: one expected record per cycle, idle values when empty.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
    end else begin
      e.en   = 1'b0;
      e.sel  = predSel;
      e.bsy  = 1'b0;
      e.dn   = 1'b0;
      e.rdy  = !rst && !flush;
      e.iter = 5'd0;
    end
    checkOutput(e);
  end

  // Present one op for a single cycle (called at a negedge); if accepted,
  // queue the expected EXEC cycles followed by the DONE cycle.
  task automatic applyStimulus(input logic [3:0] code, input logic [4:0] shamt,
                               input int cycles, input logic expAccept);
    exp_t e;
    op_valid = 1'b1;
    op_code  = code;
    op_shamt = shamt;
    #1;
    checks++;
    if (op_ready !== expAccept) begin
      errors++;
      $display("[TB] FAIL accept op=%h got ready=%b want %b", code, op_ready, expAccept);
    end
    if (expAccept) begin
      if (cycles > 0) predSel = code;
      for (int k = 1; k <= cycles; k++) begin
        e.en   = 1'b1;
        e.sel  = code;
        e.bsy  = 1'b1;
        e.dn   = 1'b0;
        e.rdy  = 1'b0;
        e.iter = 5'(cycles - k + 1);
        expq.push_back(e);
      end
      e.en   = 1'b0;
      e.sel  = predSel;
      e.bsy  = 1'b0;
      e.dn   = 1'b1;
      e.rdy  = 1'b1;
      e.iter = 5'd0;
      expq.push_back(e);
    end
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // Wait (bounded) for all queued expectations to be consumed.
  task automatic drain();
    for (int w = 0; w < 64 && expq.size() != 0; w++) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d want 0", expq.size());
    end
    @(negedge clk);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{code: 4'h1, shamt: 5'd7,  cycles: 6'd1};
    vecs[1] = '{code: 4'hA, shamt: 5'd3,  cycles: 6'd3};
    vecs[2] = '{code: 4'h9, shamt: 5'd0,  cycles: 6'd0};
    vecs[3] = '{code: 4'h0, shamt: 5'd31, cycles: 6'd1};
    vecs[4] = '{code: 4'hB, shamt: 5'd2,  cycles: 6'd2};
    vecs[5] = '{code: 4'h5, shamt: 5'd0,  cycles: 6'd1};
    vecs[6] = '{code: 4'h9, shamt: 5'd5,  cycles: 6'd5};

    predSel  = 4'h0;
    rst      = 1'b1;
    flush    = 1'b0;
    op_valid = 1'b1;
    op_code  = 4'h3;
    op_shamt = 5'd0;

    // Reset held two cycles with a pending op that must not be taken.
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    op_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven single operations.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].code, vecs[i].shamt, int'(vecs[i].cycles), 1'b1);
      drain();
    end

    // Back-to-back: SRA shamt 2 presented in the DONE cycle of SLL shamt 1.
    applyStimulus(4'h9, 5'd1, 1, 1'b1);
    @(negedge clk);
    applyStimulus(4'hB, 5'd2, 2, 1'b1);
    drain();

    // Flush on the 5th EXEC cycle of SRA shamt 31 with a competing op.
    applyStimulus(4'hB, 5'd31, 31, 1'b1);
    repeat (4) @(negedge clk);
    flush    = 1'b1;
    op_valid = 1'b1;
    op_code  = 4'h1;
    op_shamt = 5'd0;
    expq.delete();
    #1;
    checks++;
    if (op_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush-ready got %b want 0", op_ready);
    end
    @(negedge clk);
    flush    = 1'b0;
    op_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of SRL shamt 10.
    applyStimulus(4'hA, 5'd10, 10, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    expq.delete();
    predSel = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Recovery after reset.
    applyStimulus(4'h2, 5'd0, 1, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
